// File: rtl/ess_trigger_gen.sv
// rtl/ess_trigger_gen.sv - emergency stop signal initiator driven by sampled hard braking
//
// Purpose:
//   Watches vehicle speed on a periodic sample strobe and, once hard braking
//   has been seen on CONFIRM_SAMPLES consecutive samples, emits a one-cycle
//   ess_trigger pulse for the hazard-light block. While braking stays hard the
//   pulse is repeated every REFRESH_TICKS samples so the flash never lapses.
//   Leaving hard braking passes through a COOLDOWN of COOLDOWN_TICKS samples.
//
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   tick_sample      in   one-cycle sample strobe
//   speed[7:0]       in   current speed in km/h, unsigned
//   brake_pressed    in   brake pedal level
//   is_accel_pressed in   accelerator pedal level
//   ess_trigger      out  one-cycle hazard flash request
//   ess_state[1:0]   out  0 IDLE, 1 MONITOR, 2 HOLD, 3 COOLDOWN
//   ess_event_count  out  initial fires (refreshes excluded), saturating at 255

module ess_trigger_gen #(
  parameter int unsigned MIN_SPEED       = 30,
  parameter int unsigned DECEL_THRESH    = 2,
  parameter int unsigned CONFIRM_SAMPLES = 3,
  parameter int unsigned REFRESH_TICKS   = 20,
  parameter int unsigned COOLDOWN_TICKS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_sample,
  input  logic [7:0] speed,
  input  logic       brake_pressed,
  input  logic       is_accel_pressed,
  output logic       ess_trigger,
  output logic [1:0] ess_state,
  output logic [7:0] ess_event_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MONITOR  = 2'd1,
    S_HOLD     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  localparam logic [7:0] MIN_SPEED_C = 8'(MIN_SPEED);
  localparam logic [7:0] DECEL_C     = 8'(DECEL_THRESH);
  localparam logic [7:0] CONFIRM_C   = 8'(CONFIRM_SAMPLES);
  localparam logic [7:0] REFRESH_C   = 8'(REFRESH_TICKS);
  localparam logic [7:0] COOLDOWN_C  = 8'(COOLDOWN_TICKS);

  state_e     state_q, state_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] refresh_cnt_q, refresh_cnt_d;
  logic [7:0] cd_cnt_q, cd_cnt_d;
  logic [7:0] prev_speed_q, prev_speed_d;
  logic       prev_valid_q, prev_valid_d;
  logic       trig_q, trig_d;
  logic [7:0] event_cnt_q, event_cnt_d;

  logic [7:0] decel;
  logic       qualify;
  logic [7:0] hit_inc;
  logic [7:0] refresh_inc;
  logic [7:0] cd_dec;

  // Unsigned drop only; a speed increase reads as zero deceleration.
  assign decel = (prev_speed_q > speed) ? (prev_speed_q - speed) : 8'd0;

  // Accelerator in the qualify term is what suppresses a pulse on a tick
  // where the confirm count would otherwise complete.
  assign qualify = prev_valid_q & brake_pressed & ~is_accel_pressed &
                   (prev_speed_q >= MIN_SPEED_C) & (decel >= DECEL_C);

  assign hit_inc     = hit_cnt_q + 8'd1;
  assign refresh_inc = refresh_cnt_q + 8'd1;
  assign cd_dec      = cd_cnt_q - 8'd1;

  always_comb begin
    state_d       = state_q;
    hit_cnt_d     = hit_cnt_q;
    refresh_cnt_d = refresh_cnt_q;
    cd_cnt_d      = cd_cnt_q;
    prev_speed_d  = prev_speed_q;
    prev_valid_d  = prev_valid_q;
    event_cnt_d   = event_cnt_q;
    trig_d        = 1'b0;

    if (tick_sample) begin
      prev_speed_d = speed;
      prev_valid_d = 1'b1;
      // The first tick after reset only primes prev_speed.
      if (prev_valid_q) begin
        unique case (state_q)
          S_IDLE: begin
            if (brake_pressed) begin
              state_d   = S_MONITOR;
              hit_cnt_d = qualify ? 8'd1 : 8'd0;
            end
          end
          S_MONITOR: begin
            if (qualify) begin
              hit_cnt_d = hit_inc;
              if (hit_inc >= CONFIRM_C) begin
                trig_d        = 1'b1;
                event_cnt_d   = (event_cnt_q == 8'hFF) ? 8'hFF : event_cnt_q + 8'd1;
                refresh_cnt_d = 8'd0;
                state_d       = S_HOLD;
              end
            end else begin
              hit_cnt_d = 8'd0;
              if (!brake_pressed) begin
                state_d = S_IDLE;
              end
            end
          end
          S_HOLD: begin
            if (is_accel_pressed || !brake_pressed || (speed == 8'd0)) begin
              state_d  = S_COOLDOWN;
              cd_cnt_d = COOLDOWN_C;
            end else if (qualify) begin
              if (refresh_inc >= REFRESH_C) begin
                trig_d        = 1'b1;
                refresh_cnt_d = 8'd0;
              end else begin
                refresh_cnt_d = refresh_inc;
              end
            end else begin
              refresh_cnt_d = 8'd0;
            end
          end
          S_COOLDOWN: begin
            cd_cnt_d = cd_dec;
            if (cd_dec == 8'd0) begin
              state_d   = S_IDLE;
              hit_cnt_d = 8'd0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if ((state_q == S_HOLD) && is_accel_pressed) begin
      // Accelerator ends HOLD immediately, not just on the next sample.
      state_d  = S_COOLDOWN;
      cd_cnt_d = COOLDOWN_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hit_cnt_q     <= 8'd0;
      refresh_cnt_q <= 8'd0;
      cd_cnt_q      <= 8'd0;
      prev_speed_q  <= 8'd0;
      prev_valid_q  <= 1'b0;
      trig_q        <= 1'b0;
      event_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      hit_cnt_q     <= hit_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      cd_cnt_q      <= cd_cnt_d;
      prev_speed_q  <= prev_speed_d;
      prev_valid_q  <= prev_valid_d;
      trig_q        <= trig_d;
      event_cnt_q   <= event_cnt_d;
    end
  end

  assign ess_trigger     = trig_q;
  assign ess_state       = state_q;
  assign ess_event_count = event_cnt_q;

endmodule

// File: tb/tb_ess_trigger_gen.sv
// tb/tb_ess_trigger_gen.sv - self-checking bench for ess_trigger_gen
module tb_ess_trigger_gen;

  logic       clk;
  logic       rst;
  logic       tick_sample;
  logic [7:0] speed;
  logic       brake_pressed;
  logic       is_accel_pressed;
  logic       ess_trigger;
  logic [1:0] ess_state;
  logic [7:0] ess_event_count;

  ess_trigger_gen dut (
    .clk              (clk),
    .rst              (rst),
    .tick_sample      (tick_sample),
    .speed            (speed),
    .brake_pressed    (brake_pressed),
    .is_accel_pressed (is_accel_pressed),
    .ess_trigger      (ess_trigger),
    .ess_state        (ess_state),
    .ess_event_count  (ess_event_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integers, names are the behavioural phases.
  localparam int IDLE = 0, MONITOR = 1, HOLD = 2, COOLDOWN = 3;
  int m_phase, m_streak, m_since_pulse, m_cool_left, m_last_speed, m_count;
  bit m_primed, m_pulse;

  bit last_trig;
  bit saw_pulse;
  int cur_spd;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = IDLE; m_streak = 0; m_since_pulse = 0; m_cool_left = 0;
    m_last_speed = 0; m_count = 0; m_primed = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit tk, input int spd, input bit brk, input bit acc);
    bit hard;
    int drop;
    m_pulse = 0;
    if (!tk) begin
      if (m_phase == HOLD && acc) begin
        m_phase = COOLDOWN; m_cool_left = 10;
      end
      return;
    end
    if (!m_primed) begin
      m_primed = 1; m_last_speed = spd;
      return;
    end
    drop = m_last_speed - spd;
    if (drop < 0) drop = 0;
    hard = brk && !acc && (m_last_speed >= 30) && (drop >= 2);
    if (m_phase == IDLE) begin
      if (brk) begin
        m_phase = MONITOR; m_streak = hard ? 1 : 0;
      end
    end else if (m_phase == MONITOR) begin
      if (!hard) begin
        m_streak = 0;
        if (!brk) m_phase = IDLE;
      end else begin
        m_streak++;
        if (m_streak >= 3) begin
          m_pulse = 1; m_since_pulse = 0; m_phase = HOLD;
          if (m_count < 255) m_count++;
        end
      end
    end else if (m_phase == HOLD) begin
      if (acc || !brk || spd == 0) begin
        m_phase = COOLDOWN; m_cool_left = 10;
      end else if (!hard) begin
        m_since_pulse = 0;
      end else begin
        m_since_pulse++;
        if (m_since_pulse >= 20) begin
          m_pulse = 1; m_since_pulse = 0;
        end
      end
    end else begin
      m_cool_left--;
      if (m_cool_left == 0) begin
        m_phase = IDLE; m_streak = 0;
      end
    end
    m_last_speed = spd;
  endtask

  task automatic cyc(input bit tk, input int spd, input bit brk, input bit acc);
    tick_sample = tk; speed = 8'(spd); brake_pressed = brk; is_accel_pressed = acc;
    @(posedge clk);
    model_step(tk, spd, brk, acc);
    #1;
    last_trig = ess_trigger;
    if (ess_trigger) saw_pulse = 1;
    check("trig", int'(ess_trigger), int'(m_pulse));
    check("state", int'(ess_state), m_phase);
    check("count", int'(ess_event_count), m_count);
  endtask

  // Tick cycle followed by a quiet cycle; last_trig holds the tick-cycle result.
  task automatic tk(input int spd, input bit brk, input bit acc);
    bit t;
    cyc(1, spd, brk, acc);
    t = last_trig;
    cyc(0, spd, brk, acc);
    check("trig_single_cycle", int'(ess_trigger), 0);
    last_trig = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_sample = 0; brake_pressed = 0; is_accel_pressed = 0; speed = 0;
    model_reset();
    #1;
    check("rst_trig", int'(ess_trigger), 0);
    check("rst_state", int'(ess_state), 0);
    check("rst_count", int'(ess_event_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_pulse = 0;
  endtask

  initial begin
    rst = 1'b1; tick_sample = 0; speed = 0; brake_pressed = 0; is_accel_pressed = 0;
    model_reset();
    saw_pulse = 0; last_trig = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_trig", int'(ess_trigger), 0);
    check("reset_state", int'(ess_state), 0);
    check("reset_count", int'(ess_event_count), 0);
    rst = 1'b0;

    // First fire after three qualifying drops.
    tk(60, 1, 0); tk(57, 1, 0); tk(54, 1, 0);
    check("t1_no_early_pulse", int'(saw_pulse), 0);
    tk(51, 1, 0);
    check("t1_fire", int'(last_trig), 1);
    check("t1_count", int'(ess_event_count), 1);
    check("t1_state_hold", int'(ess_state), 2);
    tk(48, 1, 0);
    check("t1_no_repeat", int'(last_trig), 0);

    // Gentle braking never qualifies.
    do_reset();
    for (int s = 60; s > 52; s--) tk(s, 1, 0);
    check("t2_no_pulse", int'(saw_pulse), 0);
    check("t2_state_monitor", int'(ess_state), 1);

    // Below MIN_SPEED.
    do_reset();
    tk(25, 1, 0); tk(22, 1, 0); tk(19, 1, 0); tk(16, 1, 0);
    check("t3_no_pulse", int'(saw_pulse), 0);
    check("t3_count", int'(ess_event_count), 0);

    // Refresh after 20 further hard ticks, then accelerator cooldown.
    do_reset();
    cur_spd = 200;
    for (int i = 0; i < 4; i++) begin tk(cur_spd, 1, 0); cur_spd -= 3; end
    check("t4_first_fire", int'(last_trig), 1);
    for (int j = 1; j <= 20; j++) begin
      tk(cur_spd, 1, 0); cur_spd -= 3;
      check("t4_refresh_timing", int'(last_trig), (j == 20) ? 1 : 0);
    end
    check("t4_count_unchanged", int'(ess_event_count), 1);
    cyc(0, cur_spd, 1, 1);
    check("t5_accel_cooldown", int'(ess_state), 3);
    saw_pulse = 0;
    for (int j = 1; j <= 10; j++) begin
      tk(cur_spd, 1, 0); cur_spd -= 4;
      check("t5_cool_state", int'(ess_state), (j == 10) ? 0 : 3);
    end
    check("t5_no_pulse_in_cooldown", int'(saw_pulse), 0);

    // Accelerator on the would-be confirming tick clears the streak.
    do_reset();
    tk(60, 1, 0); tk(57, 1, 0); tk(54, 1, 0);
    tk(51, 1, 1);
    check("t6_accel_suppress", int'(last_trig), 0);
    check("t6_state_monitor", int'(ess_state), 1);
    tk(48, 1, 0); tk(45, 1, 0);
    check("t6_streak_cleared", int'(saw_pulse), 0);
    tk(42, 1, 0);
    check("t6_refire", int'(last_trig), 1);

    // Reset in the middle of a pulse, then load-only first tick.
    do_reset();
    tk(90, 1, 0); tk(86, 1, 0); tk(82, 1, 0);
    cyc(1, 78, 1, 0);
    check("t7_pulse_high", int'(ess_trigger), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t7_async_trig", int'(ess_trigger), 0);
    check("t7_async_state", int'(ess_state), 0);
    check("t7_async_count", int'(ess_event_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tk(60, 1, 0);
    check("t7_load_only", int'(ess_state), 0);
    tk(57, 1, 0);
    check("t7_then_monitor", int'(ess_state), 1);

    // Randomized phase against the model.
    cur_spd = 150;
    for (int i = 0; i < 4000; i++) begin
      bit t, b, a;
      if ($urandom_range(0, 1499) == 0) do_reset();
      t = ($urandom_range(0, 2) == 0);
      if (t) begin
        if ($urandom_range(0, 39) == 0) cur_spd = $urandom_range(0, 255);
        else cur_spd -= $urandom_range(0, 4);
        if (cur_spd < 0) cur_spd = ($urandom_range(0, 1) == 0) ? 0 : 200;
      end
      b = ($urandom_range(0, 24) != 0);
      a = ($urandom_range(0, 39) == 0);
      cyc(t, cur_spd, b, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ess_trigger_gen.md
Name: ess_trigger_gen

Overview:
- Emergency Stop Signal (ESS) initiator in the vehicle logic path.
- Samples vehicle speed on a periodic strobe and detects sustained hard braking.
- Emits single-cycle ess_trigger pulses for the hazard-light block. That block starts a 3 s flash on each pulse and cancels it on accelerator press.
- Re-pulses while hard braking persists, so the flash stays alive; enforces a cooldown before re-arming.

Parameters:
- MIN_SPEED, 30: minimum previous-sample speed (km/h) for a sample to count as hard braking.
- DECEL_THRESH, 2: minimum speed drop (km/h per sample) that counts as hard braking.
- CONFIRM_SAMPLES, 3: consecutive qualifying samples required before the first pulse.
- REFRESH_TICKS, 20: samples between repeat pulses while braking stays hard. Must be less than the responder's 3 s window at 100 ms per sample.
- COOLDOWN_TICKS, 10: samples spent in COOLDOWN before returning to IDLE.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- tick_sample  in  1  one-cycle sample strobe, nominally every 100 ms.
- speed  in  8  current vehicle speed in km/h, unsigned.
- brake_pressed  in  1  brake pedal level.
- is_accel_pressed  in  1  accelerator pedal level.
- ess_trigger  out  1  one-clk pulse requesting hazard flash.
- ess_state  out  2  FSM state: 0 IDLE, 1 MONITOR, 2 HOLD, 3 COOLDOWN.
- ess_event_count  out  8  number of initial fires (not refreshes), saturating at 255.

Behaviour:
- Reset (asynchronous): ess_trigger=0, ess_state=IDLE, ess_event_count=0, prev_speed=0, prev_valid=0, all counters 0.
- Sample processing happens only in clk cycles where tick_sample=1. All other cycles hold registers, except that ess_trigger returns to 0.
- First tick after reset: load prev_speed, set prev_valid, no evaluation.
- decel = prev_speed - speed when prev_speed > speed, else 0. Compute at 8 bits; no wrap.
- qualify = prev_valid & brake_pressed & !is_accel_pressed & (prev_speed >= MIN_SPEED) & (decel >= DECEL_THRESH).
- prev_speed <= speed on every tick, after evaluation.
- IDLE:
  - On a tick with brake_pressed, go to MONITOR.
  - If qualify is also true, set hit_cnt=1; otherwise hit_cnt=0.
- MONITOR:
  - On a tick with qualify, increment hit_cnt.
  - When hit_cnt reaches CONFIRM_SAMPLES: assert ess_trigger for exactly the next clk cycle, increment ess_event_count (saturating), clear refresh_cnt, go to HOLD.
  - On a tick without qualify: clear hit_cnt. If brake is released, go to IDLE; otherwise stay in MONITOR.
- HOLD:
  - Each tick, increment refresh_cnt while qualify holds.
  - When refresh_cnt reaches REFRESH_TICKS and qualify is still true on that tick: pulse ess_trigger again, clear refresh_cnt. ess_event_count is unchanged.
  - A tick without qualify clears refresh_cnt; stay in HOLD.
  - Exit to COOLDOWN, loading cd_cnt=COOLDOWN_TICKS, on any of:
    - is_accel_pressed=1 (checked every clk, not only on ticks);
    - brake released on a tick;
    - speed==0 on a tick.
- COOLDOWN:
  - No pulses.
  - Decrement cd_cnt on each tick; at 0, go to IDLE with hit_cnt cleared.
- Priority when events coincide:
  - rst over everything;
  - then accelerator: no pulse is generated in any cycle where is_accel_pressed=1, even if the confirm count completes;
  - then the fire/refresh decision.
- ess_trigger is never high for 2 consecutive cycles.
- Pulse latency: exactly 1 clk after the qualifying tick.
- Reset mid-HOLD or mid-pulse: ess_trigger drops immediately (asynchronous); prev_valid is cleared, so the next tick is load-only.

Test Plan:
- Reset, then ticks with speed 60, 57, 54, 51, 48 and brake=1 → ess_trigger pulses once, 1 clk after the 4th tick (3 qualifying drops), 1 cycle wide. ess_event_count=1, ess_state=HOLD.
- Same braking but drops of 1 km/h per tick (60, 59, 58, …) → no pulse; ess_state stays MONITOR.
- Hard braking from 25 km/h (25, 22, 19, 16) → no pulse, because the MIN_SPEED gate is not met.
- After the first fire, continue 3 km/h drops for 20 more ticks → second pulse on the 20th tick. ess_event_count stays 1.
- In HOLD, raise is_accel_pressed between ticks → ess_state=COOLDOWN next clk. After 10 ticks, IDLE. No pulse during cooldown, even with hard decel.
- Third qualifying tick coincides with is_accel_pressed=1 → no pulse and hit_cnt is cleared. Assert rst during HOLD → all outputs 0 immediately; first tick afterwards produces no evaluation.
